vram_arbiter: RTL and testbench

Parametrised video-RAM arbiter for one iCE40UP SPRAM bank. It arbitrates between a primary display-scan read port and a secondary CPU read/write port. The primary port has priority, but a stall counter bounds how long the CPU can wait. An optional one-entry posted-write buffer lets the CPU complete writes while the display owns the RAM. It sits between the display controller and the Hack CPU memory map and replaces the previous fixed-priority, combinational VRAM.

---
 rtl/vram_pkg.sv | 18 +
 rtl/vram_arbiter_if.sv | 31 +++
 rtl/SB_SPRAM256KA.sv | 32 +++
 rtl/spram_bank.sv | 34 +++
 rtl/vram_arbiter.sv | 132 +++++++++++++
 tb/tb_vram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM arbiter: client tags, write-buffer
// states and the native SPRAM address width.
package vram_pkg;

  localparam int SPRAM_ADDR_WIDTH = 14;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_P,
    TAG_S
  } tag_e;

  typedef enum logic {
    BUF_EMPTY,
    BUF_FULL
  } buf_state_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Display-scan (primary) and CPU (secondary) ports of the VRAM arbiter.
// The clients drive through master; the arbiter receives through slave.
interface vram_arbiter_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  p_req;
  logic [ADDR_WIDTH-1:0] p_addr;
  logic                  p_ack;
  logic                  p_valid;
  logic [15:0]           p_dout;

  logic                  s_req;
  logic                  s_we;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [15:0]           s_din;
  logic [3:0]            s_mask;
  logic                  s_ack;
  logic                  s_valid;
  logic [15:0]           s_dout;
  logic                  s_busy;

  modport master (
    output p_req, p_addr, s_req, s_we, s_addr, s_din, s_mask,
    input  p_ack, p_valid, p_dout, s_ack, s_valid, s_dout, s_busy
  );

  modport slave (
    input  p_req, p_addr, s_req, s_we, s_addr, s_din, s_mask,
    output p_ack, p_valid, p_dout, s_ack, s_valid, s_dout, s_busy
  );
endinterface

// File: rtl/SB_SPRAM256KA.sv
// Behavioural model of the iCE40UP 16Kx16 SPRAM cell, standing in for the
// vendor primitive when its cell library is not part of the build.
module SB_SPRAM256KA (
  input  logic [13:0] ADDRESS,
  input  logic [15:0] DATAIN,
  input  logic [3:0]  MASKWREN,
  input  logic        WREN,
  input  logic        CHIPSELECT,
  input  logic        CLOCK,
  input  logic        STANDBY,
  input  logic        SLEEP,
  input  logic        POWEROFF,
  output logic [15:0] DATAOUT
);
  logic [15:0] mem [0:16383];
  logic        active;

  assign active = CHIPSELECT && !STANDBY && !SLEEP && POWEROFF;

  // NOTE: the array has no reset; RAM contents are undefined at power-up and survive a logic reset.
  always_ff @(posedge CLOCK) begin
    if (active) begin
      if (WREN) begin
        for (int i = 0; i < 4; i++) begin
          if (MASKWREN[i]) mem[ADDRESS][4*i +: 4] <= DATAIN[4*i +: 4];
        end
      end else begin
        DATAOUT <= mem[ADDRESS];
      end
    end
  end
endmodule

// File: rtl/spram_bank.sv
// Thin wrapper over one SPRAM cell: always selected and awake, narrow word
// addresses zero-extended to the native 14 bits.
module spram_bank
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [15:0]           din,
  input  logic [3:0]            mask,
  input  logic                  we,
  output logic [15:0]           dout
);
  logic [SPRAM_ADDR_WIDTH-1:0] addr_ext;

  always_comb begin
    addr_ext                 = '0;
    addr_ext[ADDR_WIDTH-1:0] = addr;
  end

  SB_SPRAM256KA u_spram (
    .ADDRESS    (addr_ext),
    .DATAIN     (din),
    .MASKWREN   (mask),
    .WREN       (we),
    .CHIPSELECT (1'b1),
    .CLOCK      (clk),
    .STANDBY    (1'b0),
    .SLEEP      (1'b0),
    .POWEROFF   (1'b1),
    .DATAOUT    (dout)
  );
endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: display scan has priority, a stall counter bounds CPU waiting,
// and an optional one-entry posted-write buffer absorbs CPU writes under load.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH    = 13,
  parameter int POSTED_WRITES = 1,
  parameter int MAX_STALL     = 15
) (
  input logic           clk,
  input logic           reset,
  vram_arbiter_if.slave bus
);
  localparam logic [7:0] STALL_LIMIT = 8'(MAX_STALL);
  localparam bit         POSTED      = (POSTED_WRITES != 0);

  buf_state_e            buf_state, buf_next;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [15:0]           buf_data;
  logic [3:0]            buf_mask;
  logic [7:0]            stall_cnt, stall_next;
  tag_e                  tag, tag_next;
  logic                  s_busy_q;

  logic                  buf_full, force_grant, drain, post, s_direct;
  logic                  p_ack, s_ack;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [15:0]           ram_din, ram_dout;
  logic [3:0]            ram_mask;
  logic                  ram_we;

  assign buf_full    = POSTED && (buf_state == BUF_FULL);
  assign force_grant = bus.s_req && (stall_cnt == STALL_LIMIT);

  // NOTE: every signal gets a default before any branch so no path leaves one unassigned (no latches).
  always_comb begin
    p_ack    = 1'b0;
    s_ack    = 1'b0;
    drain    = 1'b0;
    post     = 1'b0;
    s_direct = 1'b0;
    ram_addr = bus.p_addr;
    ram_din  = bus.s_din;
    ram_mask = 4'h0;
    ram_we   = 1'b0;
    tag_next = TAG_NONE;
    buf_next = buf_state;

    if (!reset) begin
      // A forced grant whose slot is taken by a pending drain keeps stall_cnt saturated.
      if (force_grant) begin
        if (buf_full) drain = 1'b1;
        else          s_direct = 1'b1;
      end else if (bus.p_req) begin
        p_ack    = 1'b1;
        tag_next = TAG_P;
        if (POSTED && bus.s_req && bus.s_we && !buf_full) begin
          post  = 1'b1;
          s_ack = 1'b1;
        end
      end else if (buf_full) begin
        drain = 1'b1;
      end else if (bus.s_req) begin
        s_direct = 1'b1;
      end
    end

    if (drain) begin
      ram_addr = buf_addr;
      ram_din  = buf_data;
      ram_mask = buf_mask;
      ram_we   = 1'b1;
    end

    if (s_direct) begin
      s_ack    = 1'b1;
      ram_addr = bus.s_addr;
      ram_din  = bus.s_din;
      ram_mask = bus.s_mask;
      ram_we   = bus.s_we;
      tag_next = bus.s_we ? TAG_NONE : TAG_S;
    end

    if (post)       buf_next = BUF_FULL;
    else if (drain) buf_next = BUF_EMPTY;

    if (!bus.s_req || s_ack)          stall_next = '0;
    else if (stall_cnt == STALL_LIMIT) stall_next = STALL_LIMIT;
    else                               stall_next = stall_cnt + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_state <= BUF_EMPTY;
      stall_cnt <= '0;
      tag       <= TAG_NONE;
      s_busy_q  <= 1'b0;
    end else begin
      buf_state <= buf_next;
      stall_cnt <= stall_next;
      tag       <= tag_next;
      s_busy_q  <= (buf_next == BUF_FULL) || (stall_next == STALL_LIMIT);
    end
  end

  // The payload is only meaningful while the buffer is FULL, so it carries no reset.
  always_ff @(posedge clk) begin
    if (post) begin
      buf_addr <= bus.s_addr;
      buf_data <= bus.s_din;
      buf_mask <= bus.s_mask;
    end
  end

  spram_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
    .clk  (clk),
    .addr (ram_addr),
    .din  (ram_din),
    .mask (ram_mask),
    .we   (ram_we),
    .dout (ram_dout)
  );

  assign bus.p_ack   = p_ack;
  assign bus.s_ack   = s_ack;
  assign bus.p_valid = (tag == TAG_P);
  assign bus.s_valid = (tag == TAG_S);
  assign bus.p_dout  = (tag == TAG_P) ? ram_dout : 16'h0000;
  assign bus.s_dout  = (tag == TAG_S) ? ram_dout : 16'h0000;
  assign bus.s_busy  = s_busy_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized
// traffic compared cycle by cycle against a transaction-level memory model.
module tb_vram_arbiter;
  localparam int AW  = 13;
  localparam int MAX = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  vram_arbiter #(
    .ADDR_WIDTH    (AW),
    .POSTED_WRITES (1),
    .MAX_STALL     (MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: memory image, one posted write, wait counter, returning word.
  logic [15:0] ref_mem [0:(1<<AW)-1];
  bit          m_buf_full;
  int          m_buf_addr;
  logic [15:0] m_buf_data;
  logic [3:0]  m_buf_mask;
  int          m_wait;
  int          m_ret;
  logic [15:0] m_ret_data;
  bit          m_busy;
  bit          e_p_ack, e_s_ack;
  logic        obs_p_ack, obs_s_ack;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_write(input int addr, input logic [15:0] data, input logic [3:0] mask);
    for (int i = 0; i < 4; i++)
      if (mask[i]) ref_mem[addr][4*i +: 4] = data[4*i +: 4];
  endfunction

  function automatic void model_reset();
    m_buf_full = 0;
    m_wait     = 0;
    m_ret      = 0;
    m_ret_data = 16'h0;
    m_busy     = 0;
    e_p_ack    = 0;
    e_s_ack    = 0;
  endfunction

  // One clock: predict this cycle from the rules, compare at negedge, then advance.
  task automatic cycle();
    bit forced, drain, s_go, post;
    int nret;
    logic [15:0] nret_d;
    @(negedge clk);
    forced = bus.s_req && (m_wait == MAX);
    drain = 0; s_go = 0; post = 0; nret = 0; nret_d = 16'h0;
    e_p_ack = 0; e_s_ack = 0;
    if (forced) begin
      if (m_buf_full) drain = 1; else s_go = 1;
    end else if (bus.p_req) begin
      e_p_ack = 1;
      nret = 1;
      nret_d = ref_mem[int'(bus.p_addr)];
      if (bus.s_req && bus.s_we && !m_buf_full) begin
        post = 1;
        e_s_ack = 1;
      end
    end else if (m_buf_full) begin
      drain = 1;
    end else if (bus.s_req) begin
      s_go = 1;
    end
    if (s_go) begin
      e_s_ack = 1;
      if (bus.s_we) model_write(int'(bus.s_addr), bus.s_din, bus.s_mask);
      else begin
        nret = 2;
        nret_d = ref_mem[int'(bus.s_addr)];
      end
    end

    check("p_ack",   bus.p_ack,   e_p_ack);
    check("s_ack",   bus.s_ack,   e_s_ack);
    check("p_valid", bus.p_valid, m_ret == 1);
    check("s_valid", bus.s_valid, m_ret == 2);
    check("p_dout",  bus.p_dout,  (m_ret == 1) ? m_ret_data : 16'h0);
    check("s_dout",  bus.s_dout,  (m_ret == 2) ? m_ret_data : 16'h0);
    check("s_busy",  bus.s_busy,  m_busy);
    obs_p_ack = bus.p_ack;
    obs_s_ack = bus.s_ack;

    if (drain) begin
      model_write(m_buf_addr, m_buf_data, m_buf_mask);
      m_buf_full = 0;
    end
    if (post) begin
      m_buf_full = 1;
      m_buf_addr = int'(bus.s_addr);
      m_buf_data = bus.s_din;
      m_buf_mask = bus.s_mask;
    end
    if (!bus.s_req || e_s_ack) m_wait = 0;
    else if (m_wait < MAX)     m_wait = m_wait + 1;
    m_busy     = m_buf_full || (m_wait == MAX);
    m_ret      = nret;
    m_ret_data = nret_d;
    @(posedge clk);
    #1;
  endtask

  // Issue one secondary access and hold it until accepted (bounded).
  task automatic s_access(input bit we, input int addr, input logic [15:0] din, input logic [3:0] mask);
    bus.s_req  = 1'b1;
    bus.s_we   = we;
    bus.s_addr = AW'(addr);
    bus.s_din  = din;
    bus.s_mask = mask;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (obs_s_ack === 1'b1) break;
    end
    check("s_access_ack", obs_s_ack, 1'b1);
    bus.s_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    logic [15:0] rdata;

    // Reset: requests high, every output must stay 0.
    reset = 1'b1;
    bus.p_req = 1'b1; bus.p_addr = '0;
    bus.s_req = 1'b1; bus.s_we = 1'b0; bus.s_addr = '0; bus.s_din = '0; bus.s_mask = '0;
    model_reset();
    #12;
    check("rst_p_ack",   bus.p_ack,   1'b0);
    check("rst_s_ack",   bus.s_ack,   1'b0);
    check("rst_p_valid", bus.p_valid, 1'b0);
    check("rst_s_valid", bus.s_valid, 1'b0);
    check("rst_p_dout",  bus.p_dout,  16'h0);
    check("rst_s_dout",  bus.s_dout,  16'h0);
    check("rst_s_busy",  bus.s_busy,  1'b0);
    @(posedge clk); #1;
    bus.p_req = 1'b0;
    bus.s_req = 1'b0;
    reset = 1'b0;

    // Preload: 0..15 with address+0x100, 0xA5..0xA7 with 0x5555.
    for (int a = 0; a < 16; a++) s_access(1'b1, a, 16'(16'h100 + a), 4'hF);
    for (int a = 'hA5; a <= 'hA7; a++) s_access(1'b1, a, 16'h5555, 4'hF);

    // Primary stream: one word per cycle, starting one cycle after first ack.
    for (int i = 0; i < 8; i++) begin
      bus.p_req  = 1'b1;
      bus.p_addr = AW'(i);
      cycle();
      check("pstream_ack",   obs_p_ack,   1'b1);
      check("pstream_valid", bus.p_valid, 1'b1);
      check("pstream_dout",  bus.p_dout,  16'(16'h100 + i));
    end
    bus.p_req = 1'b0;
    cycle();
    check("pstream_end", bus.p_valid, 1'b0);

    // Posted write under primary load, drained on the first idle cycle.
    bus.p_req = 1'b1; bus.p_addr = AW'(1);
    bus.s_req = 1'b1; bus.s_we = 1'b1; bus.s_addr = AW'('hA5); bus.s_din = 16'hBEEF; bus.s_mask = 4'hF;
    cycle();
    check("post_ack",  obs_s_ack,  1'b1);
    check("post_busy", bus.s_busy, 1'b1);
    bus.s_req = 1'b0;
    cycle();
    cycle();
    check("post_busy_hold", bus.s_busy, 1'b1);
    bus.p_req = 1'b0;
    cycle();
    check("drain_busy_clear", bus.s_busy, 1'b0);
    s_access(1'b0, 'hA5, 16'h0, 4'h0);
    check("post_read_valid", bus.s_valid, 1'b1);
    check("post_read_dout",  bus.s_dout,  16'hBEEF);

    // Read-after-posted-write: read waits for the drain.
    bus.p_req = 1'b1; bus.p_addr = AW'(2);
    bus.s_req = 1'b1; bus.s_we = 1'b1; bus.s_addr = AW'('hA6); bus.s_din = 16'h1234; bus.s_mask = 4'hF;
    cycle();
    check("raw_post_ack", obs_s_ack, 1'b1);
    bus.s_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("raw_wait_ack", obs_s_ack, 1'b0);
    end
    bus.p_req = 1'b0;
    cycle();
    check("raw_drain_ack", obs_s_ack, 1'b0);
    cycle();
    check("raw_read_ack", obs_s_ack, 1'b1);
    bus.s_req = 1'b0;
    check("raw_read_dout", bus.s_dout, 16'h1234);

    // Starvation bound: forced grant within MAX_STALL+1 cycles.
    bus.p_req = 1'b1; bus.p_addr = AW'(3);
    bus.s_req = 1'b1; bus.s_we = 1'b0; bus.s_addr = AW'(5);
    k = 0;
    while (k < 40) begin
      cycle();
      if (obs_s_ack === 1'b1) break;
      k++;
    end
    check("starve_bound",  k <= 16,     1'b1);
    check("starve_p_ack",  obs_p_ack,   1'b0);
    bus.s_req = 1'b0;
    check("starve_dout",   bus.s_dout,  16'h0105);
    cycle();
    check("starve_resume", bus.p_valid, 1'b1);
    bus.p_req = 1'b0;

    // Nibble mask.
    s_access(1'b1, 'h10, 16'hFFFF, 4'hF);
    s_access(1'b1, 'h10, 16'h0000, 4'b0101);
    s_access(1'b0, 'h10, 16'h0, 4'h0);
    check("mask_dout", bus.s_dout, 16'hF0F0);

    // Reset with the buffer FULL and a primary read in flight.
    bus.p_req = 1'b1; bus.p_addr = AW'(4);
    bus.s_req = 1'b1; bus.s_we = 1'b1; bus.s_addr = AW'('hA7); bus.s_din = 16'hDEAD; bus.s_mask = 4'hF;
    cycle();
    check("rstd_post_ack", obs_s_ack, 1'b1);
    bus.s_req = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check("rstd_p_ack",   bus.p_ack,   1'b0);
    check("rstd_p_valid", bus.p_valid, 1'b0);
    check("rstd_p_dout",  bus.p_dout,  16'h0);
    check("rstd_s_busy",  bus.s_busy,  1'b0);
    @(posedge clk); #1;
    check("rstd_no_valid", bus.p_valid, 1'b0);
    bus.p_req = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rstd_quiet", bus.p_valid | bus.s_valid, 1'b0);
    end
    s_access(1'b0, 'hA7, 16'h0, 4'h0);
    rdata = bus.s_dout;
    check("rstd_old_data", rdata, 16'h5555);

    // Randomized traffic against the model, light then heavy primary load.
    for (int phase = 0; phase < 2; phase++) begin
      for (int n = 0; n < 300; n++) begin
        if (!(bus.p_req && !e_p_ack)) begin
          bus.p_req  = ($urandom_range(0, 99) < (phase == 0 ? 60 : 92));
          bus.p_addr = AW'($urandom_range(0, 15));
        end
        if (!(bus.s_req && !e_s_ack)) begin
          bus.s_req  = ($urandom_range(0, 99) < 45);
          bus.s_we   = 1'($urandom_range(0, 1));
          bus.s_addr = AW'($urandom_range(0, 15));
          bus.s_din  = 16'($urandom);
          bus.s_mask = 4'($urandom);
        end
        cycle();
      end
      bus.p_req = 1'b0;
      for (int n = 0; n < 40 && bus.s_req; n++) begin
        cycle();
        if (e_s_ack) bus.s_req = 1'b0;
      end
      bus.s_req = 1'b0;
      for (int n = 0; n < 4; n++) cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
